// File: rtl/rv32_memory_stage_pipe.sv
// RV32 memory stage: aligned RAM/bus store generation, load pipelining through
// MEM_LATENCY register stages, load extension, and a Wishbone-style bus FSM
// that stalls the pipeline until ack or timeout.
//
// Handshake: an instruction presented on the M1 inputs (valid_i and friends) is
// accepted on a rising edge only when advance = ~stall_i & ~stall_o. While it is
// not accepted, upstream must hold every M1 input stable. The bus side raises
// bus_req_o (cyc&stb) and keeps addr/sel/we/wdata constant until the cycle in
// which bus_ack_i is seen or the wait counter expires.
module rv32_memory_stage_pipe #(
  parameter int MEM_LATENCY = 1,
  parameter int BUS_TIMEOUT = 16,
  parameter int RAM_HI_NIB  = 1,
  parameter int BUS_NIB     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic        reg_write_o,
  output logic [4:0]  rd_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] load_data_o,
  output logic        fault_o,
  output logic [1:0]  dbg_bus_state_o
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

  localparam logic [1:0] REG_NONE = 2'd0;
  localparam logic [1:0] REG_RAM  = 2'd1;
  localparam logic [1:0] REG_BUS  = 2'd2;

  // S_DONE holds a finished bus result while stall_i keeps the access in M1,
  // so the access is not re-issued once stall_i drops.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [2:0]  funct3;
    logic [1:0]  region;
    logic        fault;
    logic [31:0] bus_data;
  } mstage_t;

  // ---------------------------------------------------------------------------
  // M1 decode
  // ---------------------------------------------------------------------------
  logic [3:0]  nib;
  logic        is_mem;
  logic [1:0]  region_in;
  logic        misalign;
  logic        unmapped;
  logic        ram_acc;
  logic        bus_acc;
  logic [3:0]  lanes;
  logic [31:0] wdata_rep;

  assign nib = alu_result_i[31:28];
  assign is_mem = valid_i & (mem_read_i | mem_write_i);

  // Address decode, alignment check, byte lanes and replicated store data.
  always_comb begin
    region_in = REG_NONE;
    misalign  = 1'b0;
    lanes     = 4'b1111;
    wdata_rep = write_data_i;
    if (nib <= 4'(RAM_HI_NIB)) begin
      region_in = REG_RAM;
    end else if (nib == 4'(BUS_NIB)) begin
      region_in = REG_BUS;
    end
    case (funct3_i[1:0])
      2'b00: begin
        lanes     = 4'b0001 << alu_result_i[1:0];
        wdata_rep = {4{write_data_i[7:0]}};
      end
      2'b01: begin
        misalign  = alu_result_i[0];
        lanes     = 4'b0011 << alu_result_i[1:0];
        wdata_rep = {2{write_data_i[15:0]}};
      end
      2'b10: begin
        misalign  = (alu_result_i[1:0] != 2'b00);
      end
      default: begin
        misalign  = 1'b0;
      end
    endcase
  end

  assign unmapped = (region_in == REG_NONE);
  assign ram_acc  = is_mem & ~misalign & (region_in == REG_RAM);
  assign bus_acc  = is_mem & ~misalign & (region_in == REG_BUS);

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------
  bus_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   slot_q, slot_d;
  logic          slot_fault_q, slot_fault_d;
  logic [31:0]   baddr_q, baddr_d;
  logic [31:0]   bwdata_q, bwdata_d;
  logic [3:0]    bsel_q, bsel_d;
  logic          bwe_q, bwe_d;
  logic          wait_s;
  logic          timeout;
  logic          advance;
  logic [31:0]   bus_slot_in;
  logic          bus_fault_in;

  assign wait_s  = (state_q == S_WAIT);
  assign timeout = wait_s & ~bus_ack_i & (cnt_q == CNT_LAST);
  assign stall_o = (wait_s & ~bus_ack_i & (cnt_q != CNT_LAST))
                 | ((state_q == S_IDLE) & bus_acc);
  assign advance = ~stall_i & ~stall_o;

  // Next-state logic for the bus FSM, wait counter, result slot and bus latches.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    slot_fault_d = slot_fault_q;
    baddr_d      = baddr_q;
    bwdata_d     = bwdata_q;
    bsel_d       = bsel_q;
    bwe_d        = bwe_q;
    case (state_q)
      S_IDLE: begin
        if (bus_acc && !stall_i) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          baddr_d  = alu_result_i;
          bwdata_d = wdata_rep;
          bsel_d   = lanes;
          bwe_d    = mem_write_i;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_ack_i) begin
          slot_d       = bus_rdata_i;
          slot_fault_d = 1'b0;
          cnt_d        = '0;
          state_d      = stall_i ? S_DONE : S_IDLE;
        end else if (timeout) begin
          slot_d       = '0;
          slot_fault_d = 1'b1;
          cnt_d        = '0;
          state_d      = stall_i ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!stall_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus FSM state, counter, result slot and bus output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      slot_q       <= '0;
      slot_fault_q <= 1'b0;
      baddr_q      <= '0;
      bwdata_q     <= '0;
      bsel_q       <= '0;
      bwe_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      slot_fault_q <= slot_fault_d;
      baddr_q      <= baddr_d;
      bwdata_q     <= bwdata_d;
      bsel_q       <= bsel_d;
      bwe_q        <= bwe_d;
    end
  end

  // bus_req_o comes straight from the state register, so reset drops it at once.
  assign bus_req_o       = wait_s;
  assign bus_we_o        = bwe_q;
  assign bus_sel_o       = bsel_q;
  assign bus_addr_o      = baddr_q;
  assign bus_wdata_o     = bwdata_q;
  assign dbg_bus_state_o = state_q;

  // Bus data / bus fault handed to the first M-stage register when M1 advances.
  always_comb begin
    bus_slot_in  = '0;
    bus_fault_in = 1'b0;
    case (state_q)
      S_WAIT: begin
        bus_slot_in  = bus_ack_i ? bus_rdata_i : 32'h0;
        bus_fault_in = timeout;
      end
      S_DONE: begin
        bus_slot_in  = slot_q;
        bus_fault_in = slot_fault_q;
      end
      default: begin
        bus_slot_in  = '0;
        bus_fault_in = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM port
  // ---------------------------------------------------------------------------
  assign mem_en_o    = advance;
  assign mem_addr_o  = alu_result_i;
  assign mem_wdata_o = wdata_rep;
  assign mem_we_o    = (advance && ram_acc && mem_write_i) ? lanes : 4'b0000;

  // ---------------------------------------------------------------------------
  // M-stage pipeline
  // ---------------------------------------------------------------------------
  mstage_t m1_d;
  mstage_t stage_q [MEM_LATENCY];

  // Pack the M1 instruction into the form carried down the M-stages.
  always_comb begin
    m1_d           = '0;
    m1_d.valid     = valid_i;
    m1_d.reg_write = valid_i & reg_write_i;
    m1_d.mem_read  = valid_i & mem_read_i;
    m1_d.rd        = rd_i;
    m1_d.alu       = alu_result_i;
    m1_d.funct3    = funct3_i;
    m1_d.region    = is_mem ? region_in : REG_NONE;
    m1_d.fault     = (is_mem & (misalign | unmapped)) | bus_fault_in;
    m1_d.bus_data  = bus_slot_in;
  end

  // M-stage shift register; every stage moves only on advance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else if (advance) begin
      stage_q[0] <= m1_d;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Last M-stage: read-data mux by the access's own region, then extension
  // ---------------------------------------------------------------------------
  mstage_t     last;
  logic [31:0] raw;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] load_d;

  assign last = stage_q[MEM_LATENCY-1];

  // Pick the source word, align the addressed byte/half, then extend it.
  always_comb begin
    raw = '0;
    if (last.region == REG_RAM) begin
      raw = mem_rdata_i;
    end else if (last.region == REG_BUS) begin
      raw = last.bus_data;
    end
    shifted = raw >> {last.alu[1:0], 3'b000};
    case (last.funct3)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = raw;
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = '0;
    endcase
    load_d = (last.valid && last.mem_read && !last.fault) ? ext : 32'h0;
  end

  // ---------------------------------------------------------------------------
  // M->W register
  // ---------------------------------------------------------------------------
  logic        w_valid_q;
  logic        w_reg_write_q;
  logic [4:0]  w_rd_q;
  logic [31:0] w_alu_q;
  logic [31:0] w_load_q;
  logic        w_fault_q;

  // Writeback register, loaded from the last M-stage on advance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_valid_q     <= 1'b0;
      w_reg_write_q <= 1'b0;
      w_rd_q        <= '0;
      w_alu_q       <= '0;
      w_load_q      <= '0;
      w_fault_q     <= 1'b0;
    end else if (advance) begin
      w_valid_q     <= last.valid;
      w_reg_write_q <= last.reg_write;
      w_rd_q        <= last.rd;
      w_alu_q       <= last.alu;
      w_load_q      <= load_d;
      w_fault_q     <= last.valid & last.fault;
    end
  end

  assign valid_o      = w_valid_q;
  assign reg_write_o  = w_reg_write_q;
  assign rd_o         = w_rd_q;
  assign alu_result_o = w_alu_q;
  assign load_data_o  = w_load_q;
  assign fault_o      = w_fault_q;

endmodule

// File: tb/tb_rv32_memory_stage_pipe.sv
// Directed bench for rv32_memory_stage_pipe (MEM_LATENCY=2, BUS_TIMEOUT=4).
module tb_rv32_memory_stage_pipe;

  localparam int ML = 2;
  localparam int TO = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n_i;
  always #5 clk = ~clk;

  logic        stall_i, valid_i, reg_write_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, write_data_i;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;
  logic        stall_o, valid_o, reg_write_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_result_o, load_data_o;
  logic        fault_o;
  logic [1:0]  dbg_bus_state_o;

  rv32_memory_stage_pipe #(
    .MEM_LATENCY(ML), .BUS_TIMEOUT(TO), .RAM_HI_NIB(1), .BUS_NIB(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .stall_i(stall_i), .valid_i(valid_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .alu_result_i(alu_result_i),
    .write_data_i(write_data_i), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stall_o(stall_o), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .rd_o(rd_o), .alu_result_o(alu_result_o),
    .load_data_o(load_data_o), .fault_o(fault_o), .dbg_bus_state_o(dbg_bus_state_o)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] wb(input logic rw, input logic flt, input logic [4:0] rd,
                                     input logic [31:0] alu, input logic [31:0] data);
    return {25'h0, rw, flt, rd, alu, data};
  endfunction

  // ---------------------------------------------------------------------------
  // RAM model: fixed read-only contents, MEM_LATENCY enabled-cycle read pipe
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    case (a[5:2])
      4'd0:    return 32'h1280_3456;
      4'd1:    return 32'h8001_7F00;
      default: return {4{a[7:0]}};
    endcase
  endfunction

  logic [31:0] rpipe [ML];
  always @(posedge clk) begin
    if (mem_en_o) begin
      rpipe[0] <= ram_word(mem_addr_o);
      for (int i = 1; i < ML; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign mem_rdata_i = rpipe[ML-1];

  // ---------------------------------------------------------------------------
  // Bus responder: ack on the ack_after-th request cycle (0 = never)
  // ---------------------------------------------------------------------------
  int          ack_after = 1;
  logic [31:0] ack_data = 32'h0;
  int          req_run = 0;
  int          req_total = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_we;
  logic        unstable = 1'b0;

  always @(negedge clk) begin
    if (bus_req_o) begin
      req_run = req_run + 1;
      req_total = req_total + 1;
      if (req_run == 1) begin
        cap_addr = bus_addr_o; cap_wdata = bus_wdata_o; cap_sel = bus_sel_o; cap_we = bus_we_o;
      end else if (bus_addr_o != cap_addr || bus_wdata_o != cap_wdata ||
                   bus_sel_o != cap_sel || bus_we_o != cap_we) begin
        unstable = 1'b1;
      end
      bus_ack_i   = (req_run == ack_after);
      bus_rdata_i = bus_ack_i ? ack_data : 32'h0;
    end else begin
      req_run   = 0;
      bus_ack_i = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: expected writeback queue, checked whenever W was loaded
  // ---------------------------------------------------------------------------
  logic [95:0] exp_q[$];
  logic        w_loaded = 1'b0;
  int          we_cnt = 0;

  always @(posedge clk) w_loaded <= rst_n_i && !stall_i && !stall_o;

  always @(negedge clk) begin
    if (mem_we_o != 4'b0) we_cnt++;
    if (rst_n_i && w_loaded && valid_o) begin
      if (exp_q.size() == 0) begin
        check("wb_extra", 96'(valid_o), 96'h0);
      end else begin
        check("wb", wb(reg_write_o, fault_o, rd_o, alu_result_o, load_data_o), exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  int          stall_cnt;
  logic [3:0]  last_we;
  logic [31:0] last_wd;
  logic        last_en;

  task automatic idle();
    valid_i = 1'b0; reg_write_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'b0; rd_i = 5'd0; alu_result_i = 32'h0; write_data_i = 32'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one instruction (starting just after a rising edge), hold it while
  // stall_o is high, then retire it to the expected queue.
  task automatic issue(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_flt);
    logic acc;
    valid_i = 1'b1; reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
    funct3_i = f3; rd_i = rd; alu_result_i = a; write_data_i = wd;
    stall_cnt = 0;
    acc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (!stall_o) begin acc = 1'b1; break; end
      stall_cnt++;
      @(posedge clk); #1;
    end
    if (!acc) check("issue_timeout", 96'h0, 96'h1);
    last_we = mem_we_o; last_wd = mem_wdata_o; last_en = mem_en_o;
    exp_q.push_back(wb(rw, exp_flt, rd, a, exp_data));
    @(posedge clk); #1;
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_i = 1'b0; stall_i = 1'b0; idle();
    for (int i = 0; i < ML; i++) rpipe[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 96'(valid_o), 96'h0);
    check("rst_load", 96'(load_data_o), 96'h0);
    check("rst_fault", 96'(fault_o), 96'h0);
    check("rst_req", 96'(bus_req_o), 96'h0);
    check("rst_stall", 96'(stall_o), 96'h0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    tick(1);

    // Load latency and sign extension: LB a=2 on word 0x12803456
    issue(1, 1, 0, 3'b000, 5'd5, 32'h0000_0002, 32'h0, 32'hFFFF_FF80, 0);
    @(negedge clk); check("lat_n1", 96'(valid_o), 96'h0);
    @(posedge clk); #1;
    @(negedge clk); check("lat_n2", 96'(valid_o), 96'h0);
    @(posedge clk); #1;
    @(negedge clk); check("lat_n3", 96'(valid_o), 96'h1);
    @(posedge clk); #1;

    // Back-to-back loads, all extension flavours
    issue(1, 1, 0, 3'b100, 5'd6,  32'h0000_0002, 32'h0, 32'h0000_0080, 0);
    issue(1, 1, 0, 3'b001, 5'd7,  32'h0000_0000, 32'h0, 32'h0000_3456, 0);
    issue(1, 1, 0, 3'b001, 5'd8,  32'h0000_0006, 32'h0, 32'hFFFF_8001, 0);
    issue(1, 1, 0, 3'b101, 5'd9,  32'h0000_0006, 32'h0, 32'h0000_8001, 0);
    issue(1, 1, 0, 3'b000, 5'd10, 32'h0000_0007, 32'h0, 32'hFFFF_FF80, 0);
    issue(1, 1, 0, 3'b100, 5'd11, 32'h1000_0005, 32'h0, 32'h0000_007F, 0);
    issue(1, 1, 0, 3'b010, 5'd12, 32'h0000_0004, 32'h0, 32'h8001_7F00, 0);

    // Stores to RAM: lanes and replication
    issue(0, 0, 1, 3'b000, 5'd0, 32'h1000_0003, 32'h0000_00A5, 32'h0, 0);
    check("sb_we", 96'(last_we), 96'h8);
    check("sb_wd", 96'(last_wd), 96'hA5A5_A5A5);
    check("sb_en", 96'(last_en), 96'h1);
    issue(0, 0, 1, 3'b001, 5'd0, 32'h0000_0002, 32'hFFFF_1234, 32'h0, 0);
    check("sh_we", 96'(last_we), 96'hC);
    check("sh_wd", 96'(last_wd), 96'h1234_1234);
    issue(0, 0, 1, 3'b010, 5'd0, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 0);
    check("sw_we", 96'(last_we), 96'hF);
    check("sw_wd", 96'(last_wd), 96'hCAFE_F00D);

    // Misaligned and unmapped accesses; ALU op to an unmapped-looking value
    issue(0, 0, 1, 3'b010, 5'd0, 32'h0000_0002, 32'h1111_2222, 32'h0, 1);
    check("mis_sw_we", 96'(last_we), 96'h0);
    issue(1, 1, 0, 3'b001, 5'd13, 32'h0000_0003, 32'h0, 32'h0, 1);
    issue(1, 1, 0, 3'b010, 5'd14, 32'h5000_0000, 32'h0, 32'h0, 1);
    issue(0, 0, 1, 3'b000, 5'd0, 32'h5000_0001, 32'h0000_0042, 32'h0, 1);
    check("unm_sb_we", 96'(last_we), 96'h0);
    issue(1, 0, 0, 3'b000, 5'd15, 32'h5000_0000, 32'h0, 32'h0, 0);

    // Bus load with ack on the third request cycle
    ack_after = 3; ack_data = 32'hDEAD_BEEF; req_total = 0; unstable = 1'b0;
    issue(1, 1, 0, 3'b010, 5'd16, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    check("bw_stall", 96'(stall_cnt), 96'd3);
    check("bw_req", 96'(req_total), 96'd3);
    check("bw_addr", 96'(cap_addr), 96'h2000_0010);
    check("bw_we", 96'(cap_we), 96'h0);
    check("bw_sel", 96'(cap_sel), 96'hF);
    check("bw_stable", 96'(unstable), 96'h0);
    @(negedge clk); check("bw_req_low", 96'(bus_req_o), 96'h0);
    @(posedge clk); #1;

    // Bus timeout: no ack
    ack_after = 0; req_total = 0;
    issue(1, 1, 0, 3'b010, 5'd17, 32'h2000_0014, 32'h0, 32'h0, 1);
    check("to_stall", 96'(stall_cnt), 96'd4);
    check("to_req", 96'(req_total), 96'd4);
    @(negedge clk); check("to_req_low", 96'(bus_req_o), 96'h0);
    @(posedge clk); #1;

    // Back-to-back bus stores, ack on first request cycle
    ack_after = 1; ack_data = 32'h0; req_total = 0; unstable = 1'b0;
    issue(0, 0, 1, 3'b010, 5'd0, 32'h2000_0020, 32'h1122_3344, 32'h0, 0);
    check("bsw_stall", 96'(stall_cnt), 96'd1);
    check("bsw_we", 96'(cap_we), 96'h1);
    check("bsw_wd", 96'(cap_wdata), 96'h1122_3344);
    issue(0, 0, 1, 3'b000, 5'd0, 32'h2000_0021, 32'h0000_0077, 32'h0, 0);
    check("bsb_sel", 96'(cap_sel), 96'h2);
    check("bsb_wd", 96'(cap_wdata), 96'h7777_7777);
    check("bsb_ramwe", 96'(last_we), 96'h0);
    check("b2b_req", 96'(req_total), 96'd2);
    req_total = 0;
    issue(1, 1, 0, 3'b010, 5'd18, 32'h2000_0012, 32'h0, 32'h0, 1);
    check("bmis_stall", 96'(stall_cnt), 96'd0);
    check("bmis_req", 96'(req_total), 96'd0);

    // External stall: outputs frozen, single RAM write
    tick(4);
    issue(1, 1, 0, 3'b010, 5'd19, 32'h0000_0004, 32'h0, 32'h8001_7F00, 0);
    we_cnt = 0;
    stall_i = 1'b1;
    valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b000; alu_result_i = 32'h0000_0001;
    write_data_i = 32'h0000_003C;
    repeat (2) begin
      @(negedge clk);
      check("stl_we", 96'(mem_we_o), 96'h0);
      check("stl_valid", 96'(valid_o), 96'h0);
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    issue(0, 0, 1, 3'b000, 5'd0, 32'h0000_0001, 32'h0000_003C, 32'h0, 0);
    check("stl_sb_we", 96'(last_we), 96'h2);
    check("stl_sb_wd", 96'(last_wd), 96'h3C3C_3C3C);
    @(negedge clk); check("stl_hold", 96'(valid_o), 96'h0);
    @(posedge clk); #1;
    tick(4);
    check("stl_we_cnt", 96'(we_cnt), 96'd1);

    // Reset in the middle of a bus wait
    issue(1, 0, 0, 3'b000, 5'd9, 32'h0000_1234, 32'h0, 32'h0, 0);
    tick(2);
    ack_after = 0;
    valid_i = 1'b1; reg_write_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010;
    rd_i = 5'd20; alu_result_i = 32'h2000_0040;
    tick(2);
    @(negedge clk);
    check("rw_pre_req", 96'(bus_req_o), 96'h1);
    check("rw_pre_valid", 96'(valid_o), 96'h1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rw_req", 96'(bus_req_o), 96'h0);
    check("rw_valid", 96'(valid_o), 96'h0);
    check("rw_wb", wb(reg_write_o, fault_o, rd_o, alu_result_o, load_data_o), 96'h0);
    check("rw_state", 96'(dbg_bus_state_o), 96'h0);
    idle();
    @(posedge clk); @(posedge clk); #1;
    rst_n_i = 1'b1;
    tick(1);
    issue(1, 1, 0, 3'b010, 5'd21, 32'h0000_0000, 32'h0, 32'h1280_3456, 0);
    tick(6);
    check("sb_drain", 96'(exp_q.size()), 96'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
